// File: rtl/fir_control_unit_if.sv
// Handshake and datapath-control bundle between fir_control_unit and its neighbours.
// master = the control unit; slave = the loader, bus slave and datapath side.
interface fir_control_unit_if #(
    parameter int unsigned ADDR_W = 4
);
    logic              dr;
    logic              lc;
    logic [1:0]        coefficient_num;
    logic              overflow;
    logic              cnt_up;
    logic              modwait;
    logic              err;
    logic [2:0]        op;
    logic [ADDR_W-1:0] src1;
    logic [ADDR_W-1:0] src2;
    logic [ADDR_W-1:0] dest;

    modport master (
        input  dr, lc, coefficient_num, overflow,
        output cnt_up, modwait, err, op, src1, src2, dest
    );

    modport slave (
        output dr, lc, coefficient_num, overflow,
        input  cnt_up, modwait, err, op, src1, src2, dest
    );
endinterface

// File: rtl/fir_control_unit.sv
// FIR sequencer: coefficient loads, 4-tap window shift, and s1*F0-s2*F1+s3*F2-s4*F3.
// Optional CTRL_RESULT_VALID_EN adds a result_valid pulse on clean completion.
module fir_control_unit #(
    parameter int unsigned ADDR_W = 4
) (
    input  logic                  clk,
    input  logic                  n_reset,
    fir_control_unit_if.master    bus
`ifdef CTRL_RESULT_VALID_EN
    ,
    output logic                  result_valid
`endif
);
    localparam logic [2:0] OP_NOP   = 3'd0;
    localparam logic [2:0] OP_COPY  = 3'd1;
    localparam logic [2:0] OP_LOAD1 = 3'd2;
    localparam logic [2:0] OP_LOAD2 = 3'd3;
    localparam logic [2:0] OP_ADD   = 3'd4;
    localparam logic [2:0] OP_SUB   = 3'd5;
    localparam logic [2:0] OP_MUL   = 3'd6;

    localparam logic [ADDR_W-1:0] R_ACC  = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] R_S1   = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] R_S2   = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] R_S3   = ADDR_W'(3);
    localparam logic [ADDR_W-1:0] R_S4   = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] R_F0   = ADDR_W'(5);
    localparam logic [ADDR_W-1:0] R_F1   = ADDR_W'(6);
    localparam logic [ADDR_W-1:0] R_F2   = ADDR_W'(7);
    localparam logic [ADDR_W-1:0] R_F3   = ADDR_W'(8);
    localparam logic [ADDR_W-1:0] R_NEW  = ADDR_W'(9);
    localparam logic [ADDR_W-1:0] R_PROD = ADDR_W'(10);

    typedef enum logic [4:0] {
        IDLE, LOADC, STORE, ZERO,
        SORT1, SORT2, SORT3, SORT4,
        MUL1, ADD1, MUL2, SUB2, MUL3, ADD3, MUL4, SUB4,
        EIDLE
    } state_t;

    state_t            state, nxt;
    logic [2:0]        n_op;
    logic [ADDR_W-1:0] n_src1, n_src2, n_dest;
    logic              n_cnt_up, n_err;

    always_comb begin
        nxt = IDLE;
        case (state)
            IDLE, EIDLE: begin
                if (bus.lc)      nxt = LOADC;
                else if (bus.dr) nxt = STORE;
                else             nxt = state;
            end
            LOADC: nxt = IDLE;
            STORE: nxt = bus.dr ? ZERO : EIDLE;
            ZERO:  nxt = SORT1;
            SORT1: nxt = SORT2;
            SORT2: nxt = SORT3;
            SORT3: nxt = SORT4;
            SORT4: nxt = MUL1;
            MUL1:  nxt = ADD1;
            ADD1:  nxt = bus.overflow ? EIDLE : MUL2;
            MUL2:  nxt = SUB2;
            SUB2:  nxt = bus.overflow ? EIDLE : MUL3;
            MUL3:  nxt = ADD3;
            ADD3:  nxt = bus.overflow ? EIDLE : MUL4;
            MUL4:  nxt = SUB4;
            SUB4:  nxt = bus.overflow ? EIDLE : IDLE;
            default: nxt = IDLE;
        endcase
    end

    // Outputs are decoded from the next state and registered, so they line up with state.
    always_comb begin
        n_op     = OP_NOP;
        n_src1   = '0;
        n_src2   = '0;
        n_dest   = '0;
        n_cnt_up = 1'b0;
        n_err    = 1'b0;
        case (nxt)
            LOADC: begin n_op = OP_LOAD2; n_dest = R_F0 + ADDR_W'(bus.coefficient_num); end
            STORE: begin n_op = OP_LOAD1; n_dest = R_NEW; n_cnt_up = 1'b1; end
            ZERO:  begin n_op = OP_SUB; n_src1 = R_ACC; n_src2 = R_ACC; n_dest = R_ACC; end
            SORT1: begin n_op = OP_COPY; n_src1 = R_S2;  n_dest = R_S1; end
            SORT2: begin n_op = OP_COPY; n_src1 = R_S3;  n_dest = R_S2; end
            SORT3: begin n_op = OP_COPY; n_src1 = R_S4;  n_dest = R_S3; end
            SORT4: begin n_op = OP_COPY; n_src1 = R_NEW; n_dest = R_S4; end
            MUL1:  begin n_op = OP_MUL; n_src1 = R_S1; n_src2 = R_F0; n_dest = R_PROD; end
            MUL2:  begin n_op = OP_MUL; n_src1 = R_S2; n_src2 = R_F1; n_dest = R_PROD; end
            MUL3:  begin n_op = OP_MUL; n_src1 = R_S3; n_src2 = R_F2; n_dest = R_PROD; end
            MUL4:  begin n_op = OP_MUL; n_src1 = R_S4; n_src2 = R_F3; n_dest = R_PROD; end
            ADD1, ADD3: begin n_op = OP_ADD; n_src1 = R_ACC; n_src2 = R_PROD; n_dest = R_ACC; end
            SUB2, SUB4: begin n_op = OP_SUB; n_src1 = R_ACC; n_src2 = R_PROD; n_dest = R_ACC; end
            EIDLE: n_err = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state       <= IDLE;
            bus.op      <= OP_NOP;
            bus.src1    <= '0;
            bus.src2    <= '0;
            bus.dest    <= '0;
            bus.cnt_up  <= 1'b0;
            bus.err     <= 1'b0;
            bus.modwait <= 1'b0;
`ifdef CTRL_RESULT_VALID_EN
            result_valid <= 1'b0;
`endif
        end else begin
            state       <= nxt;
            bus.op      <= n_op;
            bus.src1    <= n_src1;
            bus.src2    <= n_src2;
            bus.dest    <= n_dest;
            bus.cnt_up  <= n_cnt_up;
            bus.err     <= n_err;
            bus.modwait <= (nxt != IDLE) && (nxt != EIDLE);
`ifdef CTRL_RESULT_VALID_EN
            result_valid <= (state == SUB4) && (nxt == IDLE);
`endif
        end
    end
endmodule

// File: tb/tb_fir_control_unit.sv
// Directed bench for fir_control_unit: reset, coefficient load, sample sequence,
// overflow abort, withdrawn sample, lc/dr priority and mid-sequence reset.
module tb_fir_control_unit;
    localparam int unsigned ADDR_W = 4;

    logic clk;
    logic n_reset;
    int   n_checks = 0;
    int   n_errors = 0;

    fir_control_unit_if #(.ADDR_W(ADDR_W)) bus ();

`ifdef CTRL_RESULT_VALID_EN
    logic result_valid;
    fir_control_unit #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .n_reset(n_reset), .bus(bus), .result_valid(result_valid)
    );
`else
    fir_control_unit #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .n_reset(n_reset), .bus(bus)
    );
`endif

    // Expected STORE..SUB4 stream
    int exp_op   [14] = '{2, 5, 1, 1, 1, 1, 6, 4, 6, 5, 6, 4, 6, 5};
    int exp_dest [14] = '{9, 0, 1, 2, 3, 4, 10, 0, 10, 0, 10, 0, 10, 0};
    int exp_src1 [14] = '{0, 0, 2, 3, 4, 9, 1, 0, 2, 0, 3, 0, 4, 0};
    int exp_src2 [14] = '{0, 0, 0, 0, 0, 0, 5, 10, 6, 10, 7, 10, 8, 10};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_row(input int i);
        check_eq($sformatf("op[%0d]", i), int'(bus.op), exp_op[i]);
        check_eq($sformatf("dest[%0d]", i), int'(bus.dest), exp_dest[i]);
        check_eq($sformatf("src1[%0d]", i), int'(bus.src1), exp_src1[i]);
        check_eq($sformatf("src2[%0d]", i), int'(bus.src2), exp_src2[i]);
        check_eq($sformatf("modwait[%0d]", i), int'(bus.modwait), 1);
        check_eq($sformatf("cnt_up[%0d]", i), int'(bus.cnt_up), (i == 0) ? 1 : 0);
        check_eq($sformatf("err[%0d]", i), int'(bus.err), 0);
    endtask

    task automatic check_quiet(input string tag, input int exp_err);
        check_eq({tag, "_op"}, int'(bus.op), 0);
        check_eq({tag, "_modwait"}, int'(bus.modwait), 0);
        check_eq({tag, "_err"}, int'(bus.err), exp_err);
        check_eq({tag, "_cnt_up"}, int'(bus.cnt_up), 0);
        check_eq({tag, "_dest"}, int'(bus.dest), 0);
    endtask

    initial begin
        bus.dr = 1'b0;
        bus.lc = 1'b0;
        bus.coefficient_num = 2'd0;
        bus.overflow = 1'b0;
        n_reset = 1'b1;
        #2 n_reset = 1'b0;
        #1;
        check_quiet("reset", 0);
        step();
        step();
        n_reset = 1'b1;

        // Coefficient load F2
        bus.lc = 1'b1;
        bus.coefficient_num = 2'd2;
        step();
        check_eq("loadc_op", int'(bus.op), 3);
        check_eq("loadc_dest", int'(bus.dest), 7);
        check_eq("loadc_modwait", int'(bus.modwait), 1);
        bus.lc = 1'b0;
        step();
        check_quiet("after_loadc", 0);

        // Full sample sequence
        bus.dr = 1'b1;
        for (int i = 0; i < 14; i++) begin
            step();
            check_row(i);
            if (i == 1) bus.dr = 1'b0;
        end
        step();
        check_quiet("seq_done", 0);
`ifdef CTRL_RESULT_VALID_EN
        check_eq("result_valid_pulse", int'(result_valid), 1);
        step();
        check_eq("result_valid_clear", int'(result_valid), 0);
`endif

        // Overflow during SUB2 aborts to EIDLE
        bus.dr = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            check_row(i);
            if (i == 1) bus.dr = 1'b0;
        end
        bus.overflow = 1'b1;
        step();
        bus.overflow = 1'b0;
        check_quiet("ovf_eidle", 1);
        step();
        check_quiet("eidle_hold", 1);
`ifdef CTRL_RESULT_VALID_EN
        check_eq("ovf_no_result_valid", int'(result_valid), 0);
`endif

        // Leave EIDLE via a sample, then withdraw it during STORE
        bus.dr = 1'b1;
        step();
        check_row(0);
        bus.dr = 1'b0;
        step();
        check_quiet("withdrawn", 1);

        // lc from EIDLE clears err
        bus.lc = 1'b1;
        bus.coefficient_num = 2'd0;
        step();
        bus.lc = 1'b0;
        check_eq("eidle_loadc_op", int'(bus.op), 3);
        check_eq("eidle_loadc_dest", int'(bus.dest), 5);
        check_eq("eidle_loadc_err", int'(bus.err), 0);
        step();
        check_quiet("back_idle", 0);

        // lc and dr together: load first, then sample
        bus.lc = 1'b1;
        bus.dr = 1'b1;
        bus.coefficient_num = 2'd3;
        step();
        bus.lc = 1'b0;
        check_eq("prio_op", int'(bus.op), 3);
        check_eq("prio_dest", int'(bus.dest), 8);
        check_eq("prio_cnt_up", int'(bus.cnt_up), 0);
        step();
        check_quiet("prio_idle", 0);
        for (int i = 0; i < 9; i++) begin
            step();
            check_row(i);
            if (i == 1) bus.dr = 1'b0;
            if (i == 6) bus.overflow = 1'b1;  // overflow in MUL1 must be ignored
            if (i == 7) bus.overflow = 1'b0;
        end

        // Reset in MUL2 aborts immediately
        n_reset = 1'b0;
        #1;
        check_quiet("async_reset", 0);
        step();
        check_quiet("reset_mul2", 0);
        n_reset = 1'b1;
        step();
        check_quiet("post_reset", 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got 0 expected 1");
        $fatal(1, "timeout");
    end
endmodule
